// File: rtl/game_pkg.sv
// Shared encodings for the game-mode controller: FSM states, mode codes,
// HEX0 digit values and the width helper used to size the second prescaler.
package game_pkg;

    typedef enum logic [2:0] {
        ST_MENU,
        ST_INGAME,
        ST_PAUSED,
        ST_ROUND_END,
        ST_LEADERBOARD,
        ST_ENDGAME
    } state_t;

    localparam logic [3:0] MODE_MENU        = 4'b0000;
    localparam logic [3:0] MODE_INGAME      = 4'b0011;
    localparam logic [3:0] MODE_PAUSED      = 4'b0111;
    localparam logic [3:0] MODE_ROUND_END   = 4'b0001;
    localparam logic [3:0] MODE_LEADERBOARD = 4'b1001;
    localparam logic [3:0] MODE_ENDGAME     = 4'b0101;

    localparam logic [6:0] HEX_MENU        = 7'd0;
    localparam logic [6:0] HEX_INGAME      = 7'd1;
    localparam logic [6:0] HEX_PAUSED      = 7'd3;
    localparam logic [6:0] HEX_ROUND_END   = 7'd4;
    localparam logic [6:0] HEX_LEADERBOARD = 7'd5;
    localparam logic [6:0] HEX_ENDGAME     = 7'd2;

    // Number of bits needed to hold value (at least 1).
    function automatic int clog2(input int value);
        int w;
        w = 1;
        while ((longint'(1) << w) <= longint'(value))
            w = w + 1;
        return w;
    endfunction

endpackage

// File: rtl/sec_prescaler.sv
// One-second tick generator: counts 0..CLK_HZ-1 while enabled, holds its
// count when disabled, and restarts from zero on clr.
module sec_prescaler
    import game_pkg::*;
#(
    parameter int CLK_HZ = 50000000
) (
    input  logic CLOCK_50,
    input  logic resetn,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int            CW  = clog2(CLK_HZ - 1);
    localparam logic [CW-1:0] TOP = CW'(CLK_HZ - 1);

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == TOP);

    always_ff @(posedge CLOCK_50) begin
        if (!resetn)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= tick ? '0 : cnt + 1'b1;
    end

endmodule

// File: rtl/game_mode_ctrl.sv
// Multi-round game-mode sequencer: menu / play / pause / round end /
// leaderboard / end game, with round countdown, saturating total and best score.
module game_mode_ctrl
    import game_pkg::*;
#(
    parameter int CLK_HZ       = 50000000,
    parameter int GAME_SECONDS = 60,
    parameter int NUM_ROUNDS   = 3,
    parameter int LB_SECONDS   = 5,
    parameter int SCORE_W      = 8
) (
    input  logic               CLOCK_50,
    input  logic               resetn,
    input  logic               key_begin,
    input  logic               key_pause,
    input  logic               user_quit,
    input  logic               game_over,
    input  logic [SCORE_W-1:0] round_score,
    output logic [3:0]         mode_code,
    output logic [6:0]         hex0holder,
    output logic               ingame_on,
    output logic [7:0]         time_left,
    output logic [3:0]         round_idx,
    output logic [SCORE_W-1:0] total_score,
    output logic [SCORE_W-1:0] best_score,
    output logic               new_best
);

    localparam logic [7:0]         GAME_T     = 8'(GAME_SECONDS);
    localparam logic [3:0]         LAST_ROUND = 4'(NUM_ROUNDS - 1);
    localparam logic [7:0]         LB_LAST    = 8'(LB_SECONDS - 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;

    state_t state, state_n;

    logic               begin_q, pause_q, begin_e, pause_e;
    logic               tick, pre_en, pre_clr;
    logic               timeout, to_round_end, quit;
    logic [SCORE_W-1:0] score_cap, sum_sat;
    logic [SCORE_W:0]   sum_raw;
    logic [7:0]         lb_cnt;

    assign begin_e      = key_begin & ~begin_q;
    assign pause_e      = key_pause & ~pause_q;
    assign quit         = user_quit && (state != ST_MENU);
    assign timeout      = tick && (time_left == 8'd1);
    assign to_round_end = game_over || timeout;

    assign sum_raw = {1'b0, total_score} + {1'b0, score_cap};
    assign sum_sat = sum_raw[SCORE_W] ? SCORE_MAX : sum_raw[SCORE_W-1:0];

    // Resuming from PAUSED is not an entry, so the prescaler keeps its phase.
    assign pre_en  = (state == ST_INGAME) || (state == ST_LEADERBOARD);
    assign pre_clr = ((state_n == ST_INGAME) && (state == ST_MENU || state == ST_ROUND_END)) ||
                     ((state_n == ST_LEADERBOARD) && (state != ST_LEADERBOARD));

    sec_prescaler #(.CLK_HZ(CLK_HZ)) u_sec (
        .CLOCK_50 (CLOCK_50),
        .resetn   (resetn),
        .en       (pre_en),
        .clr      (pre_clr),
        .tick     (tick)
    );

    always_ff @(posedge CLOCK_50) begin
        if (!resetn)
            state <= ST_MENU;
        else
            state <= state_n;
    end

    always_comb begin
        state_n    = state;
        mode_code  = MODE_MENU;
        hex0holder = HEX_MENU;
        ingame_on  = 1'b0;
        case (state)
            ST_MENU: begin
                if (begin_e) state_n = ST_INGAME;
            end
            ST_INGAME: begin
                mode_code  = MODE_INGAME;
                hex0holder = HEX_INGAME;
                ingame_on  = 1'b1;
                if (quit)              state_n = ST_MENU;
                else if (to_round_end) state_n = ST_ROUND_END;
                else if (pause_e)      state_n = ST_PAUSED;
            end
            ST_PAUSED: begin
                mode_code  = MODE_PAUSED;
                hex0holder = HEX_PAUSED;
                if (quit)         state_n = ST_MENU;
                else if (pause_e) state_n = ST_INGAME;
            end
            ST_ROUND_END: begin
                mode_code  = MODE_ROUND_END;
                hex0holder = HEX_ROUND_END;
                if (quit)                         state_n = ST_MENU;
                else if (round_idx == LAST_ROUND) state_n = ST_LEADERBOARD;
                else                              state_n = ST_INGAME;
            end
            ST_LEADERBOARD: begin
                mode_code  = MODE_LEADERBOARD;
                hex0holder = HEX_LEADERBOARD;
                if (quit)                          state_n = ST_MENU;
                else if (tick && lb_cnt == LB_LAST) state_n = ST_ENDGAME;
            end
            ST_ENDGAME: begin
                mode_code  = MODE_ENDGAME;
                hex0holder = HEX_ENDGAME;
                if (quit || begin_e) state_n = ST_MENU;
            end
            default: state_n = ST_MENU;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            begin_q     <= 1'b0;
            pause_q     <= 1'b0;
            time_left   <= '0;
            round_idx   <= '0;
            total_score <= '0;
            best_score  <= '0;
            new_best    <= 1'b0;
            score_cap   <= '0;
            lb_cnt      <= '0;
        end else begin
            begin_q  <= key_begin;
            pause_q  <= key_pause;
            new_best <= 1'b0;
            if (quit) begin
                time_left   <= '0;
                round_idx   <= '0;
                total_score <= '0;
            end else begin
                case (state)
                    ST_MENU: begin
                        if (begin_e) begin
                            time_left   <= GAME_T;
                            round_idx   <= '0;
                            total_score <= '0;
                        end
                    end
                    ST_INGAME: begin
                        // A tick coinciding with a pause edge is dropped.
                        if (to_round_end) begin
                            score_cap <= round_score;
                            if (timeout) time_left <= '0;
                        end else if (!pause_e && tick) begin
                            time_left <= time_left - 8'd1;
                        end
                    end
                    ST_ROUND_END: begin
                        total_score <= sum_sat;
                        if (round_idx == LAST_ROUND) begin
                            lb_cnt <= '0;
                            if (sum_sat > best_score) begin
                                best_score <= sum_sat;
                                new_best   <= 1'b1;
                            end
                        end else begin
                            round_idx <= round_idx + 4'd1;
                            time_left <= GAME_T;
                        end
                    end
                    ST_LEADERBOARD: begin
                        if (tick) lb_cnt <= lb_cnt + 8'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_game_mode_ctrl.sv
// Bench for game_mode_ctrl: directed scenarios plus random stimulus, all
// compared each cycle against a mode-level behavioural model.
module tb_game_mode_ctrl;

    localparam int CLK_HZ = 10, GS = 3, NR = 2, LBS = 2, SW = 8;
    localparam int SMAX = (1 << SW) - 1;

    logic          CLOCK_50 = 1'b0;
    logic          resetn = 1'b0, key_begin = 1'b0, key_pause = 1'b0;
    logic          user_quit = 1'b0, game_over = 1'b0;
    logic [SW-1:0] round_score = '0;
    logic [3:0]    mode_code;
    logic [6:0]    hex0holder;
    logic          ingame_on;
    logic [7:0]    time_left;
    logic [3:0]    round_idx;
    logic [SW-1:0] total_score, best_score;
    logic          new_best;

    int n_checks = 0, n_fail = 0;

    always #5 CLOCK_50 = ~CLOCK_50;

    game_mode_ctrl #(.CLK_HZ(CLK_HZ), .GAME_SECONDS(GS), .NUM_ROUNDS(NR),
                     .LB_SECONDS(LBS), .SCORE_W(SW)) dut (
        .CLOCK_50(CLOCK_50), .resetn(resetn), .key_begin(key_begin),
        .key_pause(key_pause), .user_quit(user_quit), .game_over(game_over),
        .round_score(round_score), .mode_code(mode_code), .hex0holder(hex0holder),
        .ingame_on(ingame_on), .time_left(time_left), .round_idx(round_idx),
        .total_score(total_score), .best_score(best_score), .new_best(new_best)
    );

    logic [40:0] act;
    assign act = {mode_code, hex0holder, ingame_on, time_left, round_idx,
                  total_score, best_score, new_best};

    // Reference model: game modes and seconds tracked as plain integers.
    localparam int MENU = 0, PLAY = 1, PAUSE = 2, REND = 3, LB = 4, FIN = 5;
    int MODE_TAB[6] = '{0, 3, 7, 1, 9, 5};
    int HEX_TAB[6]  = '{0, 1, 3, 4, 5, 2};
    int m_mode = MENU, m_phase = 0, m_time = 0, m_round = 0, m_total = 0;
    int m_best = 0, m_cap = 0, m_lbsec = 0;
    bit m_nb = 0, m_pb = 0, m_pp = 0;

    task automatic model_step();
        bit be, pe, tk, timeout;
        if (!resetn) begin
            m_mode = MENU; m_phase = 0; m_time = 0; m_round = 0; m_total = 0;
            m_best = 0; m_cap = 0; m_lbsec = 0; m_nb = 0; m_pb = 0; m_pp = 0;
            return;
        end
        be = key_begin && !m_pb;
        pe = key_pause && !m_pp;
        m_pb = key_begin;
        m_pp = key_pause;
        m_nb = 0;
        tk = (m_mode == PLAY || m_mode == LB) && (m_phase == CLK_HZ - 1);
        if (m_mode == PLAY || m_mode == LB) m_phase = tk ? 0 : m_phase + 1;
        timeout = tk && (m_time == 1);
        if (user_quit && m_mode != MENU) begin
            m_mode = MENU; m_time = 0; m_round = 0; m_total = 0;
        end else begin
            case (m_mode)
                MENU: if (be) begin
                    m_mode = PLAY; m_phase = 0; m_time = GS; m_round = 0; m_total = 0;
                end
                PLAY: begin
                    if (game_over || timeout) begin
                        m_cap = int'(round_score);
                        if (timeout) m_time = 0;
                        m_mode = REND;
                    end else if (pe) m_mode = PAUSE;
                    else if (tk) m_time = m_time - 1;
                end
                PAUSE: if (pe) m_mode = PLAY;
                REND: begin
                    m_total = (m_total + m_cap > SMAX) ? SMAX : m_total + m_cap;
                    if (m_round == NR - 1) begin
                        m_mode = LB; m_phase = 0; m_lbsec = 0;
                        if (m_total > m_best) begin m_best = m_total; m_nb = 1; end
                    end else begin
                        m_round = m_round + 1; m_time = GS; m_mode = PLAY; m_phase = 0;
                    end
                end
                LB: if (tk) begin
                    m_lbsec = m_lbsec + 1;
                    if (m_lbsec == LBS) m_mode = FIN;
                end
                FIN: if (be) m_mode = MENU;
                default: m_mode = MENU;
            endcase
        end
    endtask

    function automatic logic [40:0] exp_vec();
        return {4'(MODE_TAB[m_mode]), 7'(HEX_TAB[m_mode]), 1'(m_mode == PLAY),
                8'(m_time), 4'(m_round), 8'(m_total), 8'(m_best), m_nb};
    endfunction

    task automatic cyc();
        @(posedge CLOCK_50);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        resetn = 0;
        for (int c = 0; c < 3; c++) cyc();
        n_checks++;
        if (act !== 41'd0) begin
            n_fail++; $display("FAIL reset_state: got %h expected 0", act);
        end
        resetn = 1;
        cyc();
        n_checks++;
        if (act !== exp_vec()) begin
            n_fail++; $display("FAIL reset_release: got %h expected %h", act, exp_vec());
        end
    endtask

    task automatic test_begin_hold();
        key_begin = 1; round_score = 7;
        for (int c = 0; c < 50; c++) begin
            cyc();
            n_checks++;
            if (act !== exp_vec()) begin
                n_fail++; $display("FAIL begin_hold cyc %0d: got %h expected %h", c, act, exp_vec());
            end
            if (c == 0) begin
                n_checks++;
                if ({ingame_on, time_left, round_idx} !== {1'b1, 8'd3, 4'd0}) begin
                    n_fail++; $display("FAIL begin_enter: got on=%0d t=%0d r=%0d expected 1 3 0",
                                       ingame_on, time_left, round_idx);
                end
            end
        end
        user_quit = 1; cyc(); user_quit = 0; key_begin = 0;
        n_checks++;
        if (mode_code !== 4'b0000 || total_score !== '0) begin
            n_fail++; $display("FAIL begin_hold_quit: got mode=%b total=%0d expected 0000 0", mode_code, total_score);
        end
        cyc();
    endtask

    task automatic test_rounds();
        key_begin = 1; cyc(); key_begin = 0;
        for (int c = 1; c <= 31; c++) begin
            cyc();
            n_checks++;
            if (act !== exp_vec()) begin
                n_fail++; $display("FAIL rounds cyc %0d: got %h expected %h", c, act, exp_vec());
            end
            if (c == 10 || c == 20) begin
                n_checks++;
                if (time_left !== 8'(c == 10 ? 2 : 1)) begin
                    n_fail++; $display("FAIL countdown cyc %0d: got %0d expected %0d", c, time_left, c == 10 ? 2 : 1);
                end
            end
            if (c == 30) begin
                n_checks++;
                if (mode_code !== 4'b0001 || time_left !== 8'd0) begin
                    n_fail++; $display("FAIL timeout: got mode=%b t=%0d expected 0001 0", mode_code, time_left);
                end
            end
        end
        n_checks++;
        if ({mode_code, round_idx, time_left, total_score} !== {4'b0011, 4'd1, 8'd3, 8'd7}) begin
            n_fail++; $display("FAIL round2_start: got mode=%b r=%0d t=%0d total=%0d expected 0011 1 3 7",
                               mode_code, round_idx, time_left, total_score);
        end
    endtask

    task automatic test_pause();
        int n;
        for (int c = 0; c < 4; c++) cyc();
        key_pause = 1;
        for (int c = 0; c < 100; c++) begin
            cyc();
            n_checks++;
            if (act !== exp_vec() || time_left !== 8'd3 || mode_code !== 4'b0111) begin
                n_fail++; $display("FAIL paused cyc %0d: got %h expected %h", c, act, exp_vec());
            end
        end
        key_pause = 0; cyc();
        key_pause = 1;
        n = 0;
        while (n < 20) begin
            cyc(); n++;
            key_pause = 0;
            n_checks++;
            if (act !== exp_vec()) begin
                n_fail++; $display("FAIL resume cyc %0d: got %h expected %h", n, act, exp_vec());
            end
            if (time_left != 8'd3) break;
        end
        n_checks++;
        if (n != 6 || time_left !== 8'd2) begin
            n_fail++; $display("FAIL resume_tick: got %0d cycles t=%0d expected 6 cycles t=2", n, time_left);
        end
    endtask

    task automatic test_saturate();
        int lb_cycles, nb_cnt;
        round_score = 250; game_over = 1; cyc(); game_over = 0;
        n_checks++;
        if (mode_code !== 4'b0001) begin
            n_fail++; $display("FAIL sat_round_end: got %b expected 0001", mode_code);
        end
        cyc();
        n_checks++;
        if ({total_score, best_score, new_best} !== {8'd255, 8'd255, 1'b1}) begin
            n_fail++; $display("FAIL saturate: got total=%0d best=%0d nb=%0d expected 255 255 1",
                               total_score, best_score, new_best);
        end
        lb_cycles = 0; nb_cnt = 0;
        while (mode_code == 4'b1001 && lb_cycles < 40) begin
            lb_cycles++;
            if (new_best) nb_cnt++;
            cyc();
            n_checks++;
            if (act !== exp_vec()) begin
                n_fail++; $display("FAIL leaderboard cyc %0d: got %h expected %h", lb_cycles, act, exp_vec());
            end
        end
        n_checks++;
        if (lb_cycles != 20 || nb_cnt != 1 || hex0holder !== 7'd2) begin
            n_fail++; $display("FAIL lb_dwell: got cycles=%0d pulses=%0d hex=%0d expected 20 1 2",
                               lb_cycles, nb_cnt, hex0holder);
        end
    endtask

    task automatic test_second_game();
        bit nb_seen;
        nb_seen = 0;
        round_score = 50;
        for (int c = 0; c < 50; c++) begin
            key_begin = (c == 0 || c == 2);
            game_over = (c == 5 || c == 8);
            cyc();
            nb_seen |= new_best;
            n_checks++;
            if (act !== exp_vec()) begin
                n_fail++; $display("FAIL second_game cyc %0d: got %h expected %h", c, act, exp_vec());
            end
        end
        n_checks++;
        if ({mode_code, total_score, best_score, nb_seen} !== {4'b0101, 8'd100, 8'd255, 1'b0}) begin
            n_fail++; $display("FAIL no_new_best: got mode=%b total=%0d best=%0d nb=%0d expected 0101 100 255 0",
                               mode_code, total_score, best_score, nb_seen);
        end
        for (int c = 0; c < 8; c++) begin
            key_begin = (c == 0 || c == 2);
            user_quit = (c == 6);
            cyc();
            n_checks++;
            if (act !== exp_vec()) begin
                n_fail++; $display("FAIL quit_seq cyc %0d: got %h expected %h", c, act, exp_vec());
            end
        end
        key_begin = 0; user_quit = 0;
        n_checks++;
        if ({mode_code, total_score, best_score} !== {4'b0000, 8'd0, 8'd255}) begin
            n_fail++; $display("FAIL quit: got mode=%b total=%0d best=%0d expected 0000 0 255",
                               mode_code, total_score, best_score);
        end
    endtask

    task automatic test_overlap_reset();
        key_begin = 1; cyc(); key_begin = 0;
        cyc(); cyc();
        game_over = 1; key_pause = 1; cyc(); game_over = 0; key_pause = 0;
        n_checks++;
        if (mode_code !== 4'b0001 || act !== exp_vec()) begin
            n_fail++; $display("FAIL over_vs_pause: got mode=%b expected 0001", mode_code);
        end
        cyc(); cyc();
        resetn = 0; cyc(); resetn = 1;
        n_checks++;
        if (act !== 41'd0) begin
            n_fail++; $display("FAIL reset_midround: got %h expected 0", act);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            resetn      = ($urandom_range(0, 499) != 0);
            key_begin   = ($urandom_range(0, 5) == 0);
            key_pause   = ($urandom_range(0, 7) == 0);
            user_quit   = ($urandom_range(0, 199) == 0);
            game_over   = ($urandom_range(0, 39) == 0);
            round_score = SW'($urandom);
            cyc();
            n_checks++;
            if (act !== exp_vec()) begin
                n_fail++; $display("FAIL random cyc %0d: got %h expected %h", c, act, exp_vec());
            end
        end
        resetn = 1; key_begin = 0; key_pause = 0; user_quit = 0; game_over = 0;
    endtask

    initial begin
        test_reset();
        test_begin_hold();
        test_rounds();
        test_pause();
        test_saturate();
        test_second_game();
        test_overlap_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
